// File: rtl/pf_stage.sv
// Pre-fetch stage: owns the fetch PC, issues one instruction request at a time and buffers the
// returned word until IF takes it; responses made stale by a redirect are dropped.
module pf_stage #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] NPC,
  input  logic            PF_Flush,
  input  logic            PCWr,
  input  logic            IF_allowin,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic [XLEN-1:0] PF_PC,
  output logic            PF_valid,
  output logic [XLEN-1:0] PF_inst,
  output logic            PF_adel
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StCancel, StHold} state_e;

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic            r_adel;
  logic            r_redir_pend;
  logic [XLEN-1:0] r_redir_pc;

  state_e          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic            w_adel_nxt;
  logic            w_redir_pend_nxt;
  logic [XLEN-1:0] w_redir_pc_nxt;
  logic            w_load;
  logic [XLEN-1:0] w_load_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_adel       <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst       <= w_inst_nxt;
      r_adel       <= w_adel_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_nxt       = r_inst;
    w_adel_nxt       = r_adel;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_pc_nxt   = r_redir_pc;
    w_load           = 1'b0;
    w_load_pc        = NPC;

    unique case (r_state)
      StIdle: w_state_nxt = StReq;
      StReq: begin
        if (inst_addr_ok) begin
          if (r_redir_pend || PF_Flush) begin
            // The accepted request is already stale; its response must be swallowed.
            w_state_nxt      = StCancel;
            w_load           = 1'b1;
            w_load_pc        = PF_Flush ? NPC : r_redir_pc;
            w_redir_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = StWait;
          end
        end else if (PF_Flush) begin
          w_redir_pend_nxt = 1'b1;
          w_redir_pc_nxt   = NPC;
        end
      end
      StWait: begin
        if (inst_data_ok && !PF_Flush) begin
          w_inst_nxt  = inst_rdata;
          w_state_nxt = StHold;
        end else if (PF_Flush) begin
          w_load      = 1'b1;
          w_state_nxt = inst_data_ok ? StReq : StCancel;
        end
      end
      StCancel: begin
        w_load = PF_Flush;
        if (inst_data_ok) begin
          w_state_nxt = StReq;
        end
      end
      StHold: begin
        if (PF_Flush || (IF_allowin && PCWr)) begin
          w_load      = 1'b1;
          w_state_nxt = StReq;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // A misaligned target is never fetched: present it as an address-error slot instead.
    if (w_load) begin
      w_pc_nxt = w_load_pc;
      if (w_load_pc[1:0] != 2'b00) begin
        w_state_nxt = StHold;
        w_inst_nxt  = '0;
        w_adel_nxt  = 1'b1;
      end else begin
        w_adel_nxt  = 1'b0;
      end
    end
  end

  always_comb begin
    inst_req  = (r_state == StReq);
    inst_addr = r_pc;
    PF_PC     = r_pc;
    PF_valid  = (r_state == StHold) && !PF_Flush;
    PF_inst   = r_inst;
    PF_adel   = r_adel;
  end

endmodule

// File: tb/tb_pf_stage.sv
// Bench for pf_stage: directed scenarios with literal expectations, then randomized traffic
// against a transaction-level model of the fetch stage and a one-outstanding memory.
module tb_pf_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] NPC;
  logic        PF_Flush, PCWr, IF_allowin;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] PF_PC;
  logic        PF_valid;
  logic [31:0] PF_inst;
  logic        PF_adel;

  always #5 clk = ~clk;

  pf_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .NPC         (NPC),
    .PF_Flush    (PF_Flush),
    .PCWr        (PCWr),
    .IF_allowin  (IF_allowin),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .PF_PC       (PF_PC),
    .PF_valid    (PF_valid),
    .PF_inst     (PF_inst),
    .PF_adel     (PF_adel)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: started / buffer full / request accepted and awaiting data / that data is stale.
  bit          m_started, m_have, m_out, m_stale, m_redir, m_adel;
  logic [31:0] m_pc, m_inst, m_redir_pc;

  task automatic model_reset();
    m_started = 0; m_have = 0; m_out = 0; m_stale = 0; m_redir = 0; m_adel = 0;
    m_pc = RST_PC; m_inst = '0; m_redir_pc = '0;
  endtask

  task automatic model_load(input logic [31:0] a);
    m_pc = a;
    if (a[1:0] != 2'b00) begin
      m_have = 1; m_inst = '0; m_adel = 1;
    end else begin
      m_have = 0; m_adel = 0;
    end
  endtask

  task automatic model_step();
    if (!m_started) begin
      m_started = 1;
    end else if (m_have) begin
      if (PF_Flush || (IF_allowin && PCWr)) model_load(NPC);
    end else if (!m_out) begin
      if (inst_addr_ok) begin
        m_out = 1;
        m_stale = PF_Flush || m_redir;
        if (PF_Flush || m_redir) begin
          m_redir = 0;
          model_load(PF_Flush ? NPC : m_redir_pc);
        end
      end else if (PF_Flush) begin
        m_redir = 1; m_redir_pc = NPC;
      end
    end else begin
      if (inst_data_ok) begin
        m_out = 0;
        if (!m_stale && !PF_Flush) begin
          m_inst = inst_rdata; m_have = 1;
        end
        if (PF_Flush) model_load(NPC);
      end else if (PF_Flush) begin
        m_stale = 1;
        model_load(NPC);
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare against the model, advance it.
  task automatic cyc(input logic fl, input logic [31:0] npc, input logic pcwr, input logic alw,
                     input logic aok, input logic dok, input logic [31:0] rd);
    bit exp_req, exp_valid;
    @(negedge clk);
    PF_Flush = fl; NPC = npc; PCWr = pcwr; IF_allowin = alw;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    #1;
    exp_req   = m_started && !m_have && !m_out;
    exp_valid = m_have && !fl;
    check("inst_req", inst_req, exp_req);
    if (exp_req) check("inst_addr", inst_addr, m_pc);
    check("PF_PC", PF_PC, m_pc);
    check("PF_valid", PF_valid, exp_valid);
    if (exp_valid) check("PF_inst", PF_inst, m_inst);
    check("PF_adel", PF_adel, m_adel);
    model_step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, inst_req, 1'b0);
    check({tag, "_pc"}, PF_PC, RST_PC);
    check({tag, "_valid"}, PF_valid, 1'b0);
    check({tag, "_adel"}, PF_adel, 1'b0);
    check({tag, "_inst"}, PF_inst, 32'h0);
  endtask

  bit          mem_busy;
  int          mem_cnt;

  initial begin
    logic [31:0] t_npc;
    logic        t_fl, t_aok, t_dok, req_before;

    rst_n = 1'b0; PF_Flush = 0; NPC = '0; PCWr = 0; IF_allowin = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_values("rst");
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset release and first fetch
    cyc(0, 32'hBFC0_0004, 1, 1, 1, 0, 0);
    check("lit_idle_req", inst_req, 1'b0);
    cyc(0, 32'hBFC0_0004, 1, 1, 1, 0, 0);
    check("lit_first_req", inst_req, 1'b1);
    check("lit_first_addr", inst_addr, 32'hBFC0_0000);
    cyc(0, 32'hBFC0_0004, 1, 1, 0, 1, 32'h2408_0001);
    cyc(0, 32'hBFC0_0004, 1, 1, 0, 0, 0);
    check("lit_first_valid", PF_valid, 1'b1);
    check("lit_first_inst", PF_inst, 32'h2408_0001);
    cyc(0, 32'hBFC0_0008, 1, 1, 1, 0, 0);
    check("lit_second_addr", inst_addr, 32'hBFC0_0004);
    cyc(0, 32'hBFC0_0008, 1, 1, 0, 1, 32'h1111_2222);

    // Stall in HOLD
    for (int i = 0; i < 5; i++) begin
      cyc(0, 32'hBFC0_0008, 0, 1, 0, 0, 0);
      check("lit_stall_valid", PF_valid, 1'b1);
      check("lit_stall_pc", PF_PC, 32'hBFC0_0004);
      check("lit_stall_inst", PF_inst, 32'h1111_2222);
      check("lit_stall_req", inst_req, 1'b0);
    end
    cyc(0, 32'hBFC0_0008, 1, 1, 0, 0, 0);
    cyc(0, 32'hBFC0_000C, 1, 1, 1, 0, 0);
    check("lit_handoff_addr", inst_addr, 32'hBFC0_0008);

    // Flush in WAIT, stale data two cycles later
    cyc(1, 32'h8000_0100, 1, 1, 0, 0, 0);
    cyc(0, 32'h8000_0104, 1, 1, 0, 0, 0);
    check("lit_cancel_req", inst_req, 1'b0);
    cyc(0, 32'h8000_0104, 1, 1, 0, 1, 32'hDEAD_BEEF);
    check("lit_cancel_valid", PF_valid, 1'b0);

    // Flush in REQ with addr_ok held low for three cycles
    cyc(1, 32'h8000_0200, 1, 1, 0, 0, 0);
    check("lit_wflush_addr", inst_addr, 32'h8000_0100);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 32'h8000_0104, 1, 1, 0, 0, 0);
      check("lit_req_hold_addr", inst_addr, 32'h8000_0100);
    end
    cyc(0, 32'h8000_0104, 1, 1, 1, 0, 0);
    cyc(0, 32'h8000_0204, 1, 1, 0, 1, 32'hCAFE_F00D);
    check("lit_redir_cancel_req", inst_req, 1'b0);
    check("lit_redir_pc", PF_PC, 32'h8000_0200);
    cyc(0, 32'h8000_0204, 1, 1, 1, 0, 0);
    check("lit_redir_addr", inst_addr, 32'h8000_0200);
    cyc(0, 32'h8000_0204, 1, 1, 0, 1, 32'h3333_4444);

    // Misaligned redirect
    cyc(1, 32'h8000_0002, 1, 1, 0, 0, 0);
    cyc(0, 32'h8000_0010, 0, 1, 0, 0, 0);
    check("lit_adel_req", inst_req, 1'b0);
    check("lit_adel_valid", PF_valid, 1'b1);
    check("lit_adel", PF_adel, 1'b1);
    check("lit_adel_inst", PF_inst, 32'h0);
    cyc(0, 32'h8000_0010, 1, 1, 0, 0, 0);
    cyc(0, 32'h8000_0014, 1, 1, 1, 0, 0);
    check("lit_adel_clear", PF_adel, 1'b0);
    check("lit_after_adel_addr", inst_addr, 32'h8000_0010);

    // Same-cycle flush and data_ok in WAIT
    cyc(1, 32'h8000_0300, 1, 1, 0, 1, 32'h0BAD_0BAD);
    cyc(0, 32'h8000_0304, 1, 1, 0, 0, 0);
    check("lit_same_req", inst_req, 1'b1);
    check("lit_same_addr", inst_addr, 32'h8000_0300);
    check("lit_same_valid", PF_valid, 1'b0);

    // Asynchronous reset mid-transaction
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_values("midrst");
    model_reset();
    mem_busy = 0; mem_cnt = 0;
    @(posedge clk); #2 rst_n = 1'b1;

    for (int k = 0; k < 3000; k++) begin
      t_fl = ($urandom_range(0, 7) == 0);
      if (m_have && !mem_busy && $urandom_range(0, 5) == 0) begin
        t_npc = $urandom();
        t_npc[1:0] = 2'($urandom_range(1, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        t_npc = $urandom() & ~32'h3;
      end else begin
        t_npc = m_pc + 32'd4;
      end
      t_aok = !mem_busy && ($urandom_range(0, 1) == 1);
      t_dok = mem_busy && (mem_cnt == 0);
      req_before = m_started && !m_have && !m_out;
      cyc(t_fl, t_npc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          t_aok, t_dok, $urandom());
      if (t_dok) mem_busy = 0;
      else if (mem_busy && mem_cnt != 0) mem_cnt--;
      if (req_before && t_aok) begin
        mem_busy = 1;
        mem_cnt  = $urandom_range(0, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
